// File: rtl/game_tick_sequencer_if.sv
// Stage handshake between game_tick_sequencer (master) and the Flappy datapath (slave):
// per-stage step strobes out, per-stage done pulses plus collision/score results back.
interface game_tick_sequencer_if;
    logic phys_step;
    logic flap_out;
    logic obst_step;
    logic check_req;
    logic phys_done;
    logic obst_done;
    logic check_done;
    logic lose_in;
    logic score_in;

    modport master (
        output phys_step, flap_out, obst_step, check_req,
        input  phys_done, obst_done, check_done, lose_in, score_in
    );

    modport slave (
        input  phys_step, flap_out, obst_step, check_req,
        output phys_done, obst_done, check_done, lose_in, score_in
    );
endinterface

// File: rtl/game_tick_sequencer.sv
// Flappy frame scheduler: game tick, ordered physics/obstacle/collision step sequence,
// Initial/Play/Lose FSM and 2-digit BCD score. Define SINGLE_STEP_EN to tick from Step.
module game_tick_sequencer #(
    parameter int TICK_DIV      = 1666667,
    parameter int STAGE_TIMEOUT = 255
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic Start,
    input  logic Ack,
    input  logic Flap,
`ifdef SINGLE_STEP_EN
    input  logic Step,
`endif
    game_tick_sequencer_if.master stg,
    output logic q_Initial,
    output logic q_Play,
    output logic q_Lose,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic overrun
);

    // One-hot encoding so the q_* outputs are the state flops themselves.
    typedef enum logic [2:0] {
        GS_INITIAL = 3'b001,
        GS_PLAY    = 3'b010,
        GS_LOSE    = 3'b100
    } game_e;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_PHYS,
        SQ_OBST,
        SQ_CHECK
    } seq_e;

    localparam logic [7:0] TO_LAST = 8'(STAGE_TIMEOUT - 1);

    game_e      game_q, game_d;
    seq_e       seq_q, seq_d;
    logic       tick, in_play, stage_done, timeout, drop, start_play;
    logic       phys_step_q, flap_out_q, obst_step_q, check_req_q;
    logic       flap_q, overrun_q;
    logic [7:0] to_cnt;
    logic [3:0] tens_q, ones_q;

`ifdef SINGLE_STEP_EN
    assign tick = Step;
`else
    localparam int TW = $clog2(TICK_DIV);
    logic [TW-1:0] tick_cnt;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end
`endif

    assign in_play = (game_q == GS_PLAY);

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        game_d     = game_q;
        seq_d      = seq_q;
        start_play = 1'b0;
        drop       = 1'b0;

        case (seq_q)
            SQ_PHYS:  stage_done = stg.phys_done;
            SQ_OBST:  stage_done = stg.obst_done;
            SQ_CHECK: stage_done = stg.check_done;
            default:  stage_done = 1'b0;
        endcase
        timeout = (seq_q != SQ_IDLE) && !stage_done && (to_cnt == TO_LAST);

        case (game_q)
            GS_INITIAL: if (Start) begin
                game_d     = GS_PLAY;
                start_play = 1'b1;
            end
            GS_PLAY: if (seq_q == SQ_CHECK && stg.check_done && stg.lose_in) game_d = GS_LOSE;
            GS_LOSE: if (Ack) game_d = GS_INITIAL;
            default: game_d = GS_INITIAL;
        endcase

        if (!in_play) begin
            seq_d = SQ_IDLE;
        end else begin
            drop = tick && (seq_q != SQ_IDLE);
            case (seq_q)
                SQ_IDLE:  if (tick) seq_d = SQ_PHYS;
                SQ_PHYS:  if (stage_done) seq_d = SQ_OBST;  else if (timeout) seq_d = SQ_IDLE;
                SQ_OBST:  if (stage_done) seq_d = SQ_CHECK; else if (timeout) seq_d = SQ_IDLE;
                default:  if (stage_done || timeout) seq_d = SQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            game_q      <= GS_INITIAL;
            seq_q       <= SQ_IDLE;
            phys_step_q <= 1'b0;
            flap_out_q  <= 1'b0;
            obst_step_q <= 1'b0;
            check_req_q <= 1'b0;
            flap_q      <= 1'b0;
            overrun_q   <= 1'b0;
            to_cnt      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every flop samples pre-edge values.
            game_q      <= game_d;
            seq_q       <= seq_d;
            phys_step_q <= (seq_q == SQ_IDLE) && (seq_d == SQ_PHYS);
            obst_step_q <= (seq_q == SQ_PHYS) && (seq_d == SQ_OBST);
            check_req_q <= (seq_q == SQ_OBST) && (seq_d == SQ_CHECK);
            flap_out_q  <= (seq_q == SQ_IDLE) && (seq_d == SQ_PHYS) && (flap_q || (Flap && in_play));

            // A Flap on the phys_step cycle wins over the clear and carries to the next tick.
            if (!in_play)         flap_q <= 1'b0;
            else if (Flap)        flap_q <= 1'b1;
            else if (phys_step_q) flap_q <= 1'b0;

            if (seq_q == SQ_IDLE || seq_d != seq_q) to_cnt <= '0;
            else                                    to_cnt <= to_cnt + 8'd1;

            if (start_play)           overrun_q <= 1'b0;
            else if (timeout || drop) overrun_q <= 1'b1;

            if (start_play) begin
                tens_q <= '0;
                ones_q <= '0;
            end else if (in_play && stg.score_in && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
                if (ones_q == 4'd9) begin
                    ones_q <= 4'd0;
                    tens_q <= tens_q + 4'd1;
                end else begin
                    ones_q <= ones_q + 4'd1;
                end
            end
        end
    end

    assign stg.phys_step = phys_step_q;
    assign stg.flap_out  = flap_out_q;
    assign stg.obst_step = obst_step_q;
    assign stg.check_req = check_req_q;
    assign q_Initial     = game_q[0];
    assign q_Play        = game_q[1];
    assign q_Lose        = game_q[2];
    assign score_tens    = tens_q;
    assign score_ones    = ones_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Directed bench for game_tick_sequencer: cycle-exact vector table from reset, then
// hand sequences for lose hold-off, score saturation, tick drop, stage timeout and async reset.
module tb_game_tick_sequencer;

    localparam logic [7:0] I_START = 8'h80, I_ACK = 8'h40, I_FLAP = 8'h20, I_PD = 8'h10;
    localparam logic [7:0] I_OD = 8'h08, I_CD = 8'h04, I_LOSE = 8'h02, I_SC = 8'h01;
    localparam logic [3:0] S_PH = 4'b1000, S_FO = 4'b0100, S_OB = 4'b0010, S_CK = 4'b0001;
    localparam logic [2:0] QI = 3'b100, QP = 3'b010, QL = 3'b001;

    typedef struct {
        int         hold;
        logic [7:0] in;
        logic [3:0] strobes;
        logic [2:0] q;
        logic [7:0] score;
        logic       ovr;
    } vec_t;

    logic board_clk = 1'b0;
    logic Reset;
    logic Start, Ack, Flap;
    logic q_Initial, q_Play, q_Lose, overrun;
    logic [3:0] score_tens, score_ones;
    logic start_b, ack_b, flap_b;
    logic q_initial_b, q_play_b, q_lose_b, overrun_b;
    logic [3:0] tens_b, ones_b;
    logic step_in;

    int n_vec = 0;
    int n_err = 0;

    game_tick_sequencer_if bus ();
    game_tick_sequencer_if bus_b ();

    game_tick_sequencer #(.TICK_DIV(16), .STAGE_TIMEOUT(20)) dut (
        .board_clk(board_clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Flap(Flap),
`ifdef SINGLE_STEP_EN
        .Step(step_in),
`endif
        .stg(bus.master), .q_Initial(q_Initial), .q_Play(q_Play), .q_Lose(q_Lose),
        .score_tens(score_tens), .score_ones(score_ones), .overrun(overrun)
    );

    // Slow-ticking second instance so a full 20-cycle stage timeout fits between ticks.
    game_tick_sequencer #(.TICK_DIV(64), .STAGE_TIMEOUT(20)) dut_to (
        .board_clk(board_clk), .Reset(Reset), .Start(start_b), .Ack(ack_b), .Flap(flap_b),
`ifdef SINGLE_STEP_EN
        .Step(step_in),
`endif
        .stg(bus_b.master), .q_Initial(q_initial_b), .q_Play(q_play_b), .q_Lose(q_lose_b),
        .score_tens(tens_b), .score_ones(ones_b), .overrun(overrun_b)
    );

    always #5 board_clk = ~board_clk;

    task automatic step();
        @(posedge board_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v);
        {Start, Ack, Flap, bus.phys_done, bus.obst_done, bus.check_done, bus.lose_in, bus.score_in} = v;
    endtask

    function automatic logic [15:0] outs_a();
        return {bus.phys_step, bus.flap_out, bus.obst_step, bus.check_req,
                q_Initial, q_Play, q_Lose, score_tens, score_ones, overrun};
    endfunction

    function automatic logic [15:0] outs_b();
        return {bus_b.phys_step, bus_b.flap_out, bus_b.obst_step, bus_b.check_req,
                q_initial_b, q_play_b, q_lose_b, tens_b, ones_b, overrun_b};
    endfunction

    vec_t vt[25];
    logic [3:0] seen;

    initial begin
        // Cycle n is the interval after the n-th rising edge following reset release.
        vt[0]  = '{5,  8'h00,                 4'b0000,     QI, 8'h00, 1'b0};
        vt[1]  = '{1,  I_START,               4'b0000,     QP, 8'h00, 1'b0};
        vt[2]  = '{10, 8'h00,                 S_PH,        QP, 8'h00, 1'b0};
        vt[3]  = '{1,  8'h00,                 4'b0000,     QP, 8'h00, 1'b0};
        vt[4]  = '{1,  8'h00,                 4'b0000,     QP, 8'h00, 1'b0};
        vt[5]  = '{1,  I_PD,                  S_OB,        QP, 8'h00, 1'b0};
        vt[6]  = '{1,  8'h00,                 4'b0000,     QP, 8'h00, 1'b0};
        vt[7]  = '{1,  8'h00,                 4'b0000,     QP, 8'h00, 1'b0};
        vt[8]  = '{1,  I_OD,                  S_CK,        QP, 8'h00, 1'b0};
        vt[9]  = '{1,  8'h00,                 4'b0000,     QP, 8'h00, 1'b0};
        vt[10] = '{1,  8'h00,                 4'b0000,     QP, 8'h00, 1'b0};
        vt[11] = '{1,  I_CD,                  4'b0000,     QP, 8'h00, 1'b0};
        vt[12] = '{1,  I_FLAP,                4'b0000,     QP, 8'h00, 1'b0};
        vt[13] = '{6,  8'h00,                 S_PH | S_FO, QP, 8'h00, 1'b0};
        vt[14] = '{1,  I_FLAP | I_PD,         S_OB,        QP, 8'h00, 1'b0};
        vt[15] = '{1,  I_OD,                  S_CK,        QP, 8'h00, 1'b0};
        vt[16] = '{1,  I_CD,                  4'b0000,     QP, 8'h00, 1'b0};
        vt[17] = '{13, 8'h00,                 S_PH | S_FO, QP, 8'h00, 1'b0};
        vt[18] = '{1,  I_PD,                  S_OB,        QP, 8'h00, 1'b0};
        vt[19] = '{1,  I_OD,                  S_CK,        QP, 8'h00, 1'b0};
        vt[20] = '{1,  I_CD | I_SC,           4'b0000,     QP, 8'h01, 1'b0};
        vt[21] = '{13, 8'h00,                 S_PH,        QP, 8'h01, 1'b0};
        vt[22] = '{1,  I_PD,                  S_OB,        QP, 8'h01, 1'b0};
        vt[23] = '{1,  I_OD,                  S_CK,        QP, 8'h01, 1'b0};
        vt[24] = '{1,  I_CD | I_LOSE | I_SC,  4'b0000,     QL, 8'h02, 1'b0};

        step_in = 1'b0;
        Reset = 1'b1;
        drive(8'h00);
        {start_b, ack_b, flap_b} = 3'b000;
        {bus_b.phys_done, bus_b.obst_done, bus_b.check_done, bus_b.lose_in, bus_b.score_in} = 5'b0;
        repeat (2) step();
        Reset = 1'b0;

        check("reset_a", outs_a(), {4'b0000, QI, 8'h00, 1'b0});
        check("reset_b", outs_b(), {4'b0000, QI, 8'h00, 1'b0});

        for (int i = 0; i < 25; i++) begin
            drive(vt[i].in);
            repeat (vt[i].hold) step();
            check($sformatf("vec%0d", i), outs_a(),
                  {vt[i].strobes, vt[i].q, vt[i].score, vt[i].ovr});
        end
        drive(8'h00);

        // Three tick periods in LOSE: no strobes, done/flap/score inputs ignored.
        seen = 4'b0000;
        for (int i = 0; i < 48; i++) begin
            drive((i % 4 == 0) ? (I_PD | I_OD | I_CD | I_FLAP | I_SC) : 8'h00);
            step();
            seen |= {bus.phys_step, bus.flap_out, bus.obst_step, bus.check_req};
        end
        drive(8'h00);
        check("lose_no_strobes", {28'h0, seen}, 32'h0);
        check("lose_hold", {q_Initial, q_Play, q_Lose, score_tens, score_ones}, {QL, 8'h02});

        // Start and Ack together: LOSE takes only Ack, INITIAL takes only Start.
        drive(I_START | I_ACK);
        step();
        check("both_in_lose", {q_Initial, q_Play, q_Lose, score_tens, score_ones}, {QI, 8'h02});
        step();
        check("both_in_init", {q_Initial, q_Play, q_Lose, score_tens, score_ones, overrun}, {QP, 8'h00, 1'b0});
        drive(8'h00);

        // Withhold phys_done: the next tick is dropped (overrun), then the stage times out.
        for (int i = 0; i < 40 && !bus.phys_step; i++) step();
        check("drop_phys_seen", bus.phys_step, 1'b1);
        repeat (15) step();
        check("drop_ovr_before", overrun, 1'b0);
        step();
        check("drop_tick", {bus.phys_step, overrun}, 2'b01);
        repeat (4) step();
        check("drop_still_play", {q_Initial, q_Play, q_Lose}, QP);
        repeat (12) step();
        check("drop_phys_after_timeout", bus.phys_step, 1'b1);
        drive(I_PD); step();
        drive(I_OD); step();
        drive(I_CD); step();
        drive(8'h00);

        // Score: carry at 10, saturation at 99 after 101 pulses.
        drive(I_SC);
        repeat (10) step();
        check("score_10", {score_tens, score_ones}, 8'h10);
        repeat (89) step();
        check("score_99", {score_tens, score_ones}, 8'h99);
        repeat (2) step();
        drive(8'h00);
        check("score_sat", {score_tens, score_ones, overrun}, {8'h99, 1'b1});

        // Stage timeout on the slow instance: 20 cycles after obst_step.
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int i = 0; i < 80 && !bus_b.phys_step; i++) step();
        check("to_phys_seen", bus_b.phys_step, 1'b1);
        bus_b.phys_done = 1'b1; step(); bus_b.phys_done = 1'b0;
        check("to_obst_step", bus_b.obst_step, 1'b1);
        repeat (19) step();
        check("to_before", {q_play_b, overrun_b}, 2'b10);
        step();
        check("to_expired", {q_play_b, overrun_b}, 2'b11);
        bus_b.obst_done = 1'b1; step(); bus_b.obst_done = 1'b0;
        check("to_late_done_ignored", bus_b.check_req, 1'b0);

        // Asynchronous reset while in CHECK, mid-cycle.
        for (int i = 0; i < 40 && !bus.phys_step; i++) step();
        check("ar_phys_seen", bus.phys_step, 1'b1);
        drive(I_PD); step();
        drive(I_OD); step();
        drive(8'h00);
        check("ar_in_check", {bus.check_req, score_tens, score_ones, overrun}, {1'b1, 8'h99, 1'b1});
        #2 Reset = 1'b1;
        #1;
        check("ar_async_a", outs_a(), {4'b0000, QI, 8'h00, 1'b0});
        check("ar_async_b", outs_b(), {4'b0000, QI, 8'h00, 1'b0});
        step();
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_tick_sequencer.md
Name: game_tick_sequencer

Overview:
Frame scheduler for the Flappy game datapath. Runs on the 100 MHz board clock and derives a fixed game tick. On each tick in play, it issues one ordered step sequence with a done-handshake per stage: flight physics, then obstacle scroll, then collision check. Owns the Initial/Play/Lose game FSM and the 2-digit BCD score shown on SSD3/SSD0.

Parameters:
TICK_DIV, 1666667, board_clk cycles per game tick (60 Hz); minimum 8
STAGE_TIMEOUT, 255, max cycles to wait for any stage done before abort; 8-bit counter

Ports:
board_clk  in  1  100 MHz clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  level, synchronous to board_clk; begins play from INITIAL
Ack  in  1  level; returns LOSE to INITIAL
Flap  in  1  single-cycle debounced flap pulse
phys_done  in  1  flight_physics step complete (pulse)
obst_done  in  1  obstacle update complete (pulse)
check_done  in  1  collision check complete (pulse)
lose_in  in  1  collision result, sampled on the check_done cycle
score_in  in  1  pipe-passed pulse
phys_step  out  1  one-cycle physics step strobe
flap_out  out  1  flap request, valid with phys_step
obst_step  out  1  one-cycle obstacle step strobe
check_req  out  1  one-cycle collision check strobe
q_Initial, q_Play, q_Lose  out  1 each  one-hot game state
score_tens, score_ones  out  4 each  BCD score
overrun  out  1  sticky: tick dropped or stage timed out

Behaviour:
- Reset (async) forces: state INITIAL, seq IDLE, all strobes 0, flap latch 0, score 00, overrun 0, tick counter 0, timeout counter 0.
- Tick counter: free-running 0..TICK_DIV-1 in all game states. Internal tick is a 1-cycle pulse on the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.
- Game FSM:
  - INITIAL: Start -> PLAY; score cleared to 00 on this transition.
  - PLAY: the sequence reaching CHECK with check_done=1 and lose_in=1 -> LOSE. Start is ignored.
  - LOSE: Ack -> INITIAL. Start is ignored.
  - If Start and Ack are both high, only the transition legal for the current state is taken.
- Sequencer, active only in PLAY:
  - IDLE: on tick -> PHYS and assert phys_step for that cycle.
  - PHYS: wait for phys_done -> OBST with obst_step pulsed on entry.
  - OBST: wait for obst_done -> CHECK with check_req pulsed on entry.
  - CHECK: wait for check_done -> IDLE.
  - Each strobe is high for exactly 1 cycle, the cycle after the triggering event is registered, so latency is tick+1.
  - A done pulse arriving in the same cycle as its strobe is accepted.
  - Done inputs for a stage other than the current one are ignored.
- Timeout: a timeout counter resets on each stage entry. If STAGE_TIMEOUT cycles elapse without done, go to IDLE, set overrun, and leave the game state unchanged.
- Tick overrun: a tick arriving while seq is not IDLE is dropped and sets overrun. overrun clears only on Reset or on the INITIAL->PLAY transition.
- Flap:
  - A Flap pulse in PLAY sets the flap latch.
  - flap_out = latch, qualified with phys_step. The latch clears on the phys_step cycle unless a new Flap pulse arrives in that same cycle, in which case it stays set.
  - The latch is held cleared outside PLAY.
- Leaving PLAY (to LOSE) forces seq to IDLE the next cycle and issues no further strobes.
- Score:
  - A score_in pulse in PLAY increments BCD: ones 9->0 carries into tens.
  - The score saturates at 99.
  - score_in outside PLAY is ignored.
  - The score is held through LOSE and INITIAL until the next Start.
- Outputs are registered; q_* are one-hot at all times.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input Step (1-cycle pulse). The internal tick equals Step instead of the divider, for frame-by-frame debug; the divider logic is removed.
- Undefined: Step port is absent and the tick comes from the TICK_DIV counter.

Test Plan:
- TICK_DIV=16, Reset, Start at cycle 5: q_Play=1 at cycle 6. phys_step at cycle 16. With each done returned 2 cycles after its strobe, obst_step and check_req follow in order. Back to IDLE before the next tick.
- Play with lose_in=1 on check_done: q_Lose next cycle, no strobes for 3 further ticks. Ack -> q_Initial. Start -> score 00.
- 101 score_in pulses in PLAY: score_tens=9, score_ones=9. 10 pulses from 00 gives tens=1, ones=0.
- Withhold obst_done, STAGE_TIMEOUT=20: seq returns to IDLE 20 cycles after obst_step, overrun=1, q_Play stays 1.
- Flap between ticks: flap_out=1 with the next phys_step only, 0 on the following tick. Flap on the phys_step cycle: flap_out=1 on the following tick.
- Reset asserted while in CHECK: all outputs return to reset values immediately, without waiting for a clock edge.
